commit_rat: RTL and testbench
=============================

# commit_rat

Committed register alias table directly downstream of the reorder buffer's commit ports. Tracks the architectural-register-to-physical-tag mapping as of the last retired instruction. Returns superseded physical tags to the free list. On request, streams the committed map back to rename so the speculative map can be rebuilt after a flush.

## Interface
Parameters:
- WIDTH, 4, commit lanes per cycle (power of two)
- NAME_W, 5, architectural register name width (32 regs, x0 hard-wired)
- TAG_W, 7, physical tag width; tag MSB set = immediate/no physical register (e.g. 7'h40)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- IN_comValid  in  WIDTH  per-lane commit valid, lane 0 oldest
- IN_comNm  in  WIDTH×NAME_W  destination name per lane
- IN_comTag  in  WIDTH×TAG_W  destination tag per lane
- IN_mispredFlush  in  1  high while commit ports carry rollback replay, not real retirement
- OUT_freeValid  out  WIDTH  per-lane tag-return valid
- OUT_freeTag  out  WIDTH×TAG_W  returned tags
- IN_restoreReq  in  1  single-cycle request to stream the committed map
- OUT_restoreBusy  out  1  restore sequence in progress
- OUT_restoreValid  out  1  OUT_restoreTags valid this cycle
- OUT_restoreIdx  out  3  group index; group g covers names 4g..4g+3
- OUT_restoreTags  out  4×TAG_W  committed tags for the group

## Operation
- State: map[32] of TAG_W. Reset value: map[r] = r zero-extended.
- Commit lane i is effective when all of the following hold:
  - IN_comValid[i] = 1
  - IN_mispredFlush = 0
  - IN_comNm[i] ≠ 0
- Lanes with IN_mispredFlush = 1 are ignored entirely: no map write, no free.
- Each effective lane i:
  - Old tag is the map value for its name as seen after all older lanes in the same cycle.
  - If an older lane j<i in the same cycle writes the same name, the old tag is lane j's IN_comTag.
  - Otherwise the old tag is the registered map[nm].
  - OUT_freeValid[i] = 1 when the old tag MSB = 0. OUT_freeTag[i] = old tag.
- Final map[nm] = IN_comTag of the youngest effective lane for that name. Tags with MSB set are stored like any other tag.
- Ineffective lanes produce OUT_freeValid[i] = 0.
- Restore FSM:
  - IDLE: IN_restoreReq → RUN with group counter g=0; OUT_restoreBusy rises the next cycle.
  - RUN: each cycle emits OUT_restoreValid=1, OUT_restoreIdx=g, and OUT_restoreTags = registered map[4g..4g+3]. g increments by 1.
  - After g=7 is emitted, return to IDLE; OUT_restoreBusy falls the following cycle.
- IN_restoreReq while in RUN is ignored.
- Commits during RUN are still applied to the map. Streamed groups reflect the map at the start of the emitting cycle. A commit during RUN is a protocol violation; the bench asserts it never occurs.
- Reset mid-restore: FSM returns to IDLE and map returns to identity.

## Timing
- Free outputs are registered: effective commit in cycle N → OUT_freeValid/OUT_freeTag in cycle N+1. The map update is also visible from N+1.
- Restore: request at N → groups 0..7 on cycles N+1..N+8; busy high on N+1..N+8.
- Total restore latency is fixed at 8 cycles.
- Reset values of outputs:
  - OUT_freeValid = 0
  - OUT_freeTag = 0
  - OUT_restoreBusy = 0
  - OUT_restoreValid = 0
  - OUT_restoreIdx = 0
  - OUT_restoreTags = 0
- When not valid, OUT_freeTag and OUT_restoreTags hold don't-care; the bench checks only valid-qualified data.
- Group counter is 3 bits and wraps 7→0, coinciding with the return to IDLE.

## Structure
- Shared package: TAG_W, NAME_W, the immediate-tag MSB convention, RESTORE_GROUPS = 8, and the restore FSM state enum.
- One natural sub-module, rat_lane_resolve (combinational). It does the per-lane old-tag selection with same-name forwarding across lanes and a youngest-writer select. The top module holds the map registers, output registers and FSM.

## Test plan
- Reset, then restore request → 8 groups. Group 0 tags = 0,1,2,3; group 7 = 28..31; busy exactly 8 cycles.
- Lane 0 commits x5→tag 0x21 (map[5]=5) → next cycle OUT_freeValid=0001, OUT_freeTag[0]=5; later restore shows map[5]=0x21.
- Same cycle: lane 0 x7→0x30, lane 2 x7→0x31 → frees 7 (lane 0) and 0x30 (lane 2); map[7]=0x31.
- Commit x3→0x40, then x3→0x22 → first frees 3; second produces no free (old tag MSB set); map[3]=0x22.
- IN_mispredFlush=1 with all lanes valid, plus lane with nm=0 in normal mode → no frees, map unchanged.
- Reset asserted during restore group 4 → outputs zero immediately; after release, a new restore streams the identity map.

Source files
------------

// File: rtl/commit_rat_pkg.sv
// Shared constants and types for the committed register alias table.
// A tag with its MSB set denotes an immediate (no physical register behind it).
package commit_rat_pkg;

  localparam int unsigned NAME_W         = 5;
  localparam int unsigned TAG_W          = 7;
  localparam int unsigned RESTORE_GROUPS = 8;
  localparam int unsigned GROUP_SIZE     = 4;
  localparam int unsigned IMM_TAG_BIT    = TAG_W - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } restoreState_t;

endpackage

// File: rtl/rat_lane_resolve.sv
// Per-lane old-tag lookup with same-cycle forwarding from older lanes,
// and youngest-writer-wins construction of the next committed map.
module rat_lane_resolve #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NAME_W = commit_rat_pkg::NAME_W,
  parameter int unsigned TAG_W  = commit_rat_pkg::TAG_W
) (
  input  logic [WIDTH-1:0]              effective,
  input  logic [WIDTH*NAME_W-1:0]       comNm,
  input  logic [WIDTH*TAG_W-1:0]        comTag,
  input  logic [(2**NAME_W)*TAG_W-1:0]  mapCur,
  output logic [WIDTH-1:0]              freeValid,
  output logic [WIDTH*TAG_W-1:0]        freeTag,
  output logic [(2**NAME_W)*TAG_W-1:0]  mapNext
);
  import commit_rat_pkg::*;

  logic [NAME_W-1:0] laneNm;
  logic [TAG_W-1:0]  oldTag;

  // Lanes are walked oldest to youngest so later writes override earlier ones.
  always_comb begin
    freeValid = '0;
    freeTag   = '0;
    mapNext   = mapCur;
    laneNm    = '0;
    oldTag    = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      laneNm = comNm[i*NAME_W +: NAME_W];
      oldTag = mapCur[int'(laneNm)*TAG_W +: TAG_W];
      for (int j = 0; j < i; j++) begin
        if (effective[j] && (comNm[j*NAME_W +: NAME_W] == laneNm)) begin
          oldTag = comTag[j*TAG_W +: TAG_W];
        end
      end
      freeTag[i*TAG_W +: TAG_W] = oldTag;
      if (effective[i]) begin
        freeValid[i] = ~oldTag[TAG_W-1];
        mapNext[int'(laneNm)*TAG_W +: TAG_W] = comTag[i*TAG_W +: TAG_W];
      end
    end
  end

endmodule

// File: rtl/commit_rat.sv
// Committed register alias table: retires commit lanes into the map, returns
// superseded tags to the free list, and streams the map back on request.
module commit_rat #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NAME_W = commit_rat_pkg::NAME_W,
  parameter int unsigned TAG_W  = commit_rat_pkg::TAG_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          IN_comValid,
  input  logic [WIDTH*NAME_W-1:0]   IN_comNm,
  input  logic [WIDTH*TAG_W-1:0]    IN_comTag,
  input  logic                      IN_mispredFlush,
  output logic [WIDTH-1:0]          OUT_freeValid,
  output logic [WIDTH*TAG_W-1:0]    OUT_freeTag,
  input  logic                      IN_restoreReq,
  output logic                      OUT_restoreBusy,
  output logic                      OUT_restoreValid,
  output logic [2:0]                OUT_restoreIdx,
  output logic [4*TAG_W-1:0]        OUT_restoreTags
);
  import commit_rat_pkg::*;

  localparam int unsigned NREGS      = 2**NAME_W;
  localparam int unsigned GROUP_BITS = GROUP_SIZE * TAG_W;

  logic [NREGS*TAG_W-1:0] mapQ;
  logic [NREGS*TAG_W-1:0] mapNext;
  logic [WIDTH-1:0]       effective;
  logic [WIDTH-1:0]       freeValidC;
  logic [WIDTH*TAG_W-1:0] freeTagC;
  restoreState_t          state;
  logic [2:0]             groupSel;
  logic [GROUP_BITS-1:0]  groupTagsC;

  // x0 never retires and rollback replay never touches the committed map.
  always_comb begin
    effective = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      effective[i] = IN_comValid[i] && !IN_mispredFlush &&
                     (IN_comNm[i*NAME_W +: NAME_W] != '0);
    end
  end

  rat_lane_resolve #(
    .WIDTH  (WIDTH),
    .NAME_W (NAME_W),
    .TAG_W  (TAG_W)
  ) u_resolve (
    .effective (effective),
    .comNm     (IN_comNm),
    .comTag    (IN_comTag),
    .mapCur    (mapQ),
    .freeValid (freeValidC),
    .freeTag   (freeTagC),
    .mapNext   (mapNext)
  );

  // Sample the group about to be emitted from the map as it will stand then.
  always_comb begin
    groupSel   = (state == RUN) ? (OUT_restoreIdx + 3'd1) : 3'd0;
    groupTagsC = mapNext[int'(groupSel)*GROUP_BITS +: GROUP_BITS];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        mapQ[r*TAG_W +: TAG_W] <= TAG_W'(r);
      end
      OUT_freeValid <= '0;
      OUT_freeTag   <= '0;
    end else begin
      mapQ          <= mapNext;
      OUT_freeValid <= freeValidC;
      OUT_freeTag   <= freeTagC;
    end
  end

  // Restore sequencer: eight groups back to back, index wraps on exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      OUT_restoreBusy  <= 1'b0;
      OUT_restoreValid <= 1'b0;
      OUT_restoreIdx   <= 3'd0;
      OUT_restoreTags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          OUT_restoreBusy  <= 1'b0;
          OUT_restoreValid <= 1'b0;
          if (IN_restoreReq) begin
            state            <= RUN;
            OUT_restoreBusy  <= 1'b1;
            OUT_restoreValid <= 1'b1;
            OUT_restoreIdx   <= 3'd0;
            OUT_restoreTags  <= groupTagsC;
          end
        end
        RUN: begin
          OUT_restoreIdx  <= OUT_restoreIdx + 3'd1;
          OUT_restoreTags <= groupTagsC;
          if (OUT_restoreIdx == 3'(RESTORE_GROUPS - 1)) begin
            state            <= IDLE;
            OUT_restoreBusy  <= 1'b0;
            OUT_restoreValid <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          OUT_restoreBusy  <= 1'b0;
          OUT_restoreValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_commit_rat.sv
// Directed bench for commit_rat: table of commit vectors plus restore sequences.
module tb_commit_rat;
  localparam int unsigned WIDTH  = 4;
  localparam int unsigned NAME_W = 5;
  localparam int unsigned TAG_W  = 7;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [WIDTH-1:0]        IN_comValid = '0;
  logic [WIDTH*NAME_W-1:0] IN_comNm = '0;
  logic [WIDTH*TAG_W-1:0]  IN_comTag = '0;
  logic                    IN_mispredFlush = 1'b0;
  logic [WIDTH-1:0]        OUT_freeValid;
  logic [WIDTH*TAG_W-1:0]  OUT_freeTag;
  logic                    IN_restoreReq = 1'b0;
  logic                    OUT_restoreBusy;
  logic                    OUT_restoreValid;
  logic [2:0]              OUT_restoreIdx;
  logic [4*TAG_W-1:0]      OUT_restoreTags;

  commit_rat #(.WIDTH(WIDTH), .NAME_W(NAME_W), .TAG_W(TAG_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .IN_comValid      (IN_comValid),
    .IN_comNm         (IN_comNm),
    .IN_comTag        (IN_comTag),
    .IN_mispredFlush  (IN_mispredFlush),
    .OUT_freeValid    (OUT_freeValid),
    .OUT_freeTag      (OUT_freeTag),
    .IN_restoreReq    (IN_restoreReq),
    .OUT_restoreBusy  (OUT_restoreBusy),
    .OUT_restoreValid (OUT_restoreValid),
    .OUT_restoreIdx   (OUT_restoreIdx),
    .OUT_restoreTags  (OUT_restoreTags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic        flush;
    logic [19:0] nm;
    logic [27:0] tag;
    logic [3:0]  expFv;
    logic [27:0] expFt;
  } vec_t;

  vec_t       vecs [9];
  logic [6:0] want [32];
  int         nCompared = 0;
  int         nMismatched = 0;

  // Retirement while the map is being streamed is outside the protocol.
  always @(negedge clk) begin
    if (rst && OUT_restoreBusy && !IN_mispredFlush && (IN_comValid != '0))
      $error("commit applied during restore");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic setIdentity();
    for (int r = 0; r < 32; r++) want[r] = 7'(r);
  endtask

  task automatic doRestore(input int dupReqAt);
    @(posedge clk); #1 IN_restoreReq = 1'b1;
    @(posedge clk); #1 IN_restoreReq = 1'b0;
    for (int g = 0; g < 8; g++) begin
      chk($sformatf("restore busy g%0d", g), 32'(OUT_restoreBusy), 32'd1);
      chk($sformatf("restore valid g%0d", g), 32'(OUT_restoreValid), 32'd1);
      chk($sformatf("restore idx g%0d", g), 32'(OUT_restoreIdx), 32'(g));
      for (int k = 0; k < 4; k++)
        chk($sformatf("restore tag x%0d", 4*g+k), 32'(OUT_restoreTags[k*7 +: 7]), 32'(want[4*g+k]));
      IN_restoreReq = (g == dupReqAt);
      @(posedge clk); #1;
    end
    IN_restoreReq = 1'b0;
    chk("restore busy after", 32'(OUT_restoreBusy), 32'd0);
    chk("restore valid after", 32'(OUT_restoreValid), 32'd0);
    chk("restore idx after", 32'(OUT_restoreIdx), 32'd0);
    // A request seen during the last group must not start a second pass.
    @(posedge clk); #1;
    chk("restore busy idle", 32'(OUT_restoreBusy), 32'd0);
  endtask

  task automatic chkOutputsZero(input string tagName);
    chk({tagName, " freeValid"}, 32'(OUT_freeValid), 32'd0);
    chk({tagName, " freeTag"}, 32'(OUT_freeTag), 32'd0);
    chk({tagName, " busy"}, 32'(OUT_restoreBusy), 32'd0);
    chk({tagName, " rvalid"}, 32'(OUT_restoreValid), 32'd0);
    chk({tagName, " ridx"}, 32'(OUT_restoreIdx), 32'd0);
    chk({tagName, " rtags"}, 32'(OUT_restoreTags), 32'd0);
  endtask

  initial begin
    // Lane fields are concatenated lane3..lane0.
    vecs[0] = '{4'b0001, 1'b0, {5'd0, 5'd0, 5'd0, 5'd5}, {7'h0, 7'h0, 7'h0, 7'h21},
                4'b0001, {7'h0, 7'h0, 7'h0, 7'd5}};
    vecs[1] = '{4'b0101, 1'b0, {5'd0, 5'd7, 5'd0, 5'd7}, {7'h0, 7'h31, 7'h0, 7'h30},
                4'b0101, {7'h0, 7'h30, 7'h0, 7'd7}};
    vecs[2] = '{4'b0001, 1'b0, {5'd0, 5'd0, 5'd0, 5'd3}, {7'h0, 7'h0, 7'h0, 7'h40},
                4'b0001, {7'h0, 7'h0, 7'h0, 7'd3}};
    vecs[3] = '{4'b0001, 1'b0, {5'd0, 5'd0, 5'd0, 5'd3}, {7'h0, 7'h0, 7'h0, 7'h22},
                4'b0000, 28'h0};
    vecs[4] = '{4'b1111, 1'b1, {5'd6, 5'd4, 5'd2, 5'd1}, {7'h53, 7'h52, 7'h51, 7'h50},
                4'b0000, 28'h0};
    vecs[5] = '{4'b0010, 1'b0, {5'd0, 5'd0, 5'd0, 5'd0}, {7'h0, 7'h0, 7'h55, 7'h0},
                4'b0000, 28'h0};
    vecs[6] = '{4'b1111, 1'b0, {5'd10, 5'd8, 5'd9, 5'd8}, {7'h41, 7'h12, 7'h11, 7'h10},
                4'b1111, {7'd10, 7'h10, 7'd9, 7'd8}};
    vecs[7] = '{4'b1010, 1'b0, {5'd10, 5'd0, 5'd10, 5'd0}, {7'h13, 7'h0, 7'h14, 7'h0},
                4'b1000, {7'h14, 7'h0, 7'h0, 7'h0}};
    vecs[8] = '{4'b0000, 1'b0, 20'h0, 28'h0, 4'b0000, 28'h0};

    // Reset state.
    #12;
    chkOutputsZero("reset");
    @(negedge clk) rst = 1'b1;

    setIdentity();
    doRestore(-1);

    // Commit table: inputs held for one cycle, frees checked the cycle after.
    for (int v = 0; v < 9; v++) begin
      @(posedge clk); #1;
      IN_comValid     = vecs[v].valid;
      IN_mispredFlush = vecs[v].flush;
      IN_comNm        = vecs[v].nm;
      IN_comTag       = vecs[v].tag;
      @(posedge clk); #1;
      IN_comValid = '0;
      IN_mispredFlush = 1'b0;
      chk($sformatf("vec%0d freeValid", v), 32'(OUT_freeValid), 32'(vecs[v].expFv));
      for (int l = 0; l < 4; l++) begin
        if (vecs[v].expFv[l])
          chk($sformatf("vec%0d freeTag%0d", v, l), 32'(OUT_freeTag[l*7 +: 7]),
              32'(vecs[v].expFt[l*7 +: 7]));
      end
    end

    // Map after the table.
    setIdentity();
    want[3] = 7'h22; want[5] = 7'h21; want[7] = 7'h31;
    want[8] = 7'h12; want[9] = 7'h11; want[10] = 7'h13;
    doRestore(7);
    doRestore(3);

    // Reset while group 4 is on the outputs.
    @(posedge clk); #1 IN_restoreReq = 1'b1;
    @(posedge clk); #1 IN_restoreReq = 1'b0;
    for (int g = 0; g < 4; g++) begin
      @(posedge clk); #1;
    end
    chk("pre-reset idx", 32'(OUT_restoreIdx), 32'd4);
    chk("pre-reset busy", 32'(OUT_restoreBusy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chkOutputsZero("midreset");
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b1;
    setIdentity();
    doRestore(-1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
